arm_multicycle_controller: RTL and testbench

- Multicycle ARM control unit: FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB, main and ALU decode with a wider ALU op set, condition evaluation, and an internal NZCV flags register.
- Drives the shared-memory multicycle datapath. One instruction takes 3-5 cycles.
- Successor to the single-cycle decoder: parametrised ALU control width, adds EOR/TST/MOV, and handles conditional execution internally.

---
 rtl/arm_mc_pkg.sv | 69 ++++++
 rtl/arm_cond_unit.sv | 52 +++++
 rtl/arm_multicycle_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_BRLINK   = 4'd10
  } state_t;

  // ALU operations (low 3 bits of ALUControl)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_EOR   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // Instruction classes (Op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Datapath mux encodings
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_PC        = 2'd3;
  localparam logic [1:0] SRCA_RD1      = 2'd0;
  localparam logic [1:0] SRCA_PC       = 2'd1;
  localparam logic [1:0] SRCB_RD2      = 2'd0;
  localparam logic [1:0] SRCB_IMM      = 2'd1;
  localparam logic [1:0] SRCB_FOUR     = 2'd2;
  localparam logic [1:0] IMM_DP        = 2'd0;
  localparam logic [1:0] IMM_MEM       = 2'd1;
  localparam logic [1:0] IMM_BR        = 2'd2;

  // Registered control word driven to the datapath
  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       linkwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/arm_cond_unit.sv
// Condition evaluation (combinational) and the NZCV flags register.
// Latency: condex same cycle; flags update on the clock edge after a write enable.
// Backpressure: none. Ports: clk, reset (sync, active-low), cond, aluflags, nz_we, cv_we -> condex, flags.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       nz_we,
  input  logic       cv_we,
  output logic       condex,
  output logic [3:0] flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    unique case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      COND_NV: condex = 1'b0;
    endcase
  end

  // NZ and CV are written independently: logical ops keep the old carry/overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      if (nz_we) flags[3:2] <= aluflags[3:2];
      if (cv_we) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: FSM, main/ALU decode, conditional execution, NZCV flags.
// Latency: 3-5 cycles per instruction; all control outputs registered (valid in the state they belong to).
// Backpressure: none. Optional macro MC_BL_EN adds the BRLINK state for BL (else BL behaves as B).
// Ports: clk, reset (sync, active-low), Instr[19:0]=bits[31:12], ALUFlags -> datapath controls, Flags.
module arm_multicycle_controller
  import arm_mc_pkg::*;
#(
  parameter int          ALU_CTRL_W = 3,
  parameter logic [3:0]  PC_REG     = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           Instr,
  input  logic [3:0]            ALUFlags,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  LinkWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            Flags
);

  generate
    if (ALU_CTRL_W < 3) begin : g_bad_width
      $error("ALU_CTRL_W must be >= 3");
    end
  endgenerate

  // Field split of instruction bits [31:12]. Rd (bits 15:12) sits in the low
  // nibble here; bits 19:16 (Rn) are not needed by the controller.
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t state_q, state_d, st_eff;
  logic   cond_q, cond_d, cond_eff;
  ctrl_t  ctrl_q, ctrl_d;
  logic   condex;
  logic   is_bl;

  // ALU decode
  logic [2:0] alu_op;
  logic       nowrite, dp_valid, cv_upd;

  always_comb begin
    alu_op   = ALU_ADD;
    nowrite  = 1'b0;
    dp_valid = 1'b1;
    cv_upd   = 1'b0;
    unique case (funct[4:1])
      4'b0000: alu_op = ALU_AND;
      4'b0001: alu_op = ALU_EOR;
      4'b0010: begin alu_op = ALU_SUB; cv_upd = 1'b1; end
      4'b0100: begin alu_op = ALU_ADD; cv_upd = 1'b1; end
      4'b1100: alu_op = ALU_ORR;
      4'b1101: alu_op = ALU_PASSB;
      4'b1000: begin alu_op = ALU_AND; nowrite = 1'b1; end
      4'b1010: begin alu_op = ALU_SUB; nowrite = 1'b1; cv_upd = 1'b1; end
      default: begin alu_op = ALU_ADD; nowrite = 1'b1; dp_valid = 1'b0; end
    endcase
    // cmd bits of a load/store are U/B/W flags, not an opcode
    if (op != OP_DP) nowrite = 1'b0;
  end

`ifdef MC_BL_EN
  assign is_bl = funct[4];
`else
  assign is_bl = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = is_bl ? S_BRLINK : S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
      S_BRLINK:   state_d = S_BRANCH;
      default:    state_d = S_FETCH;
    endcase
  end

  assign cond_d   = (state_q == S_DECODE) ? condex : cond_q;
  // Reset forces the FETCH decode into the output register as well.
  assign st_eff   = reset ? state_d : S_FETCH;
  assign cond_eff = reset & cond_d;

  // Output decode for the state being entered, so outputs are registered yet
  // line up with the state they belong to.
  always_comb begin
    ctrl_d       = '0;
    ctrl_d.aluop = ALU_ADD;
    unique case (st_eff)
      S_FETCH: begin
        ctrl_d.irwrite   = 1'b1;
        ctrl_d.pcwrite   = 1'b1;
        ctrl_d.alusrca   = SRCA_PC;
        ctrl_d.alusrcb   = SRCB_FOUR;
        ctrl_d.resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl_d.alusrca = SRCA_PC;
        ctrl_d.alusrcb = SRCB_FOUR;
      end
      S_MEMADR: begin
        ctrl_d.alusrca   = SRCA_RD1;
        ctrl_d.alusrcb   = SRCB_IMM;
        ctrl_d.immsrc    = IMM_MEM;
        ctrl_d.regsrc[1] = ~funct[0];
      end
      S_MEMREAD:  ctrl_d.adrsrc = 1'b1;
      S_MEMWB: begin
        ctrl_d.resultsrc = RES_DATA;
        ctrl_d.regwrite  = cond_eff;
        ctrl_d.pcwrite   = cond_eff & (rd == PC_REG) & ~nowrite;
      end
      S_MEMWRITE: begin
        ctrl_d.adrsrc    = 1'b1;
        ctrl_d.memwrite  = cond_eff;
        ctrl_d.regsrc[1] = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_d.alusrcb = SRCB_RD2;
        ctrl_d.aluop   = alu_op;
      end
      S_EXECUTEI: begin
        ctrl_d.alusrcb = SRCB_IMM;
        ctrl_d.immsrc  = IMM_DP;
        ctrl_d.aluop   = alu_op;
      end
      S_ALUWB: begin
        ctrl_d.resultsrc = RES_ALUOUT;
        ctrl_d.regwrite  = cond_eff & ~nowrite;
        ctrl_d.pcwrite   = cond_eff & (rd == PC_REG) & ~nowrite;
      end
      S_BRANCH: begin
        ctrl_d.alusrca   = SRCA_RD1;
        ctrl_d.alusrcb   = SRCB_IMM;
        ctrl_d.resultsrc = RES_ALURESULT;
        ctrl_d.regsrc[0] = 1'b1;
        ctrl_d.immsrc    = IMM_BR;
        ctrl_d.pcwrite   = cond_eff;
      end
      S_BRLINK: begin
        ctrl_d.resultsrc = RES_PC;
        ctrl_d.regwrite  = cond_eff;
        ctrl_d.linkwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
    end
    ctrl_q <= ctrl_d;
  end

  // Flag writes happen at the end of EXECUTE, gated by the latched condition,
  // so they can never influence the same instruction's writeback.
  logic in_exec, nz_we, cv_we;
  assign in_exec = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign nz_we   = in_exec & funct[0] & cond_q & dp_valid;
  assign cv_we   = nz_we & cv_upd;

  arm_cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .aluflags (ALUFlags),
    .nz_we    (nz_we),
    .cv_we    (cv_we),
    .condex   (condex),
    .flags    (Flags)
  );

  assign PCWrite   = ctrl_q.pcwrite;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign MemWrite  = ctrl_q.memwrite;
  assign IRWrite   = ctrl_q.irwrite;
  assign RegWrite  = ctrl_q.regwrite;
`ifdef MC_BL_EN
  assign LinkWrite = ctrl_q.linkwrite;
`else
  assign LinkWrite = 1'b0;
`endif
  assign ResultSrc = ctrl_q.resultsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ImmSrc    = ctrl_q.immsrc;
  assign RegSrc    = ctrl_q.regsrc;

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = ctrl_q.aluop;
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller: instruction sequences with hand-computed controls.
// Latency: n/a.
// Backpressure: n/a.
module tb_arm_multicycle_controller;
  import arm_mc_pkg::*;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, LinkWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;
  int memw_cnt;

  arm_multicycle_controller #(.ALU_CTRL_W(3), .PC_REG(4'hF)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .LinkWrite  (LinkWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] word);
    Instr = word[31:12];
  endtask

  task automatic chk_state(input string tag, input state_t s);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  initial begin
    reset    = 1'b0;
    ALUFlags = 4'b0000;
    load(32'hE2812005);               // ADD R2,R1,#5
    step(); step();
    chk_state("rst_state", S_FETCH);
    check("rst_flags", 32'(Flags), 32'h0);
    check("rst_irwrite", 32'(IRWrite), 32'd1);
    check("rst_pcwrite", 32'(PCWrite), 32'd1);
    check("rst_alusrcb", 32'(ALUSrcB), 32'd2);
    reset = 1'b1;

    step(); chk_state("add_decode", S_DECODE);
    check("add_dec_irwrite", 32'(IRWrite), 32'd0);
    step(); chk_state("add_execi", S_EXECUTEI);
    check("add_aluctl", 32'(ALUControl), 32'd0);
    check("add_exe_regwrite", 32'(RegWrite), 32'd0);
    check("add_alusrcb", 32'(ALUSrcB), 32'd1);
    step(); chk_state("add_aluwb", S_ALUWB);
    check("add_wb_regwrite", 32'(RegWrite), 32'd1);
    check("add_wb_pcwrite", 32'(PCWrite), 32'd0);
    step(); chk_state("add_fetch", S_FETCH);
    check("add_fetch_regwrite", 32'(RegWrite), 32'd0);

    // CMP R2,#0 with Z from the ALU
    load(32'hE3520000); ALUFlags = 4'b0100;
    step(); check("cmp_dec_regwrite", 32'(RegWrite), 32'd0);
    step(); check("cmp_aluctl", 32'(ALUControl), 32'd1);
    check("cmp_exe_regwrite", 32'(RegWrite), 32'd0);
    step(); check("cmp_flags", 32'(Flags), 32'h4);
    check("cmp_wb_regwrite", 32'(RegWrite), 32'd0);
    step(); ALUFlags = 4'b0000;

    // BNE with Z=1: not taken
    load(32'h1A000002);
    step(); step(); chk_state("bne_z1_state", S_BRANCH);
    check("bne_z1_pcwrite", 32'(PCWrite), 32'd0);
    check("bne_immsrc", 32'(ImmSrc), 32'd2);
    check("bne_regsrc", 32'(RegSrc), 32'd1);
    step();

    // Clear Z via CMP, then BNE is taken
    load(32'hE3520000);
    repeat (4) step();
    check("cmp2_flags", 32'(Flags), 32'h0);
    load(32'h1A000002);
    step(); step(); check("bne_z0_pcwrite", 32'(PCWrite), 32'd1);
    step();

    // LDR R2,[R1,#4]
    load(32'hE5912004);
    step(); step(); chk_state("ldr_memadr", S_MEMADR);
    check("ldr_alusrca", 32'(ALUSrcA), 32'd0);
    check("ldr_immsrc", 32'(ImmSrc), 32'd1);
    step(); chk_state("ldr_memread", S_MEMREAD);
    check("ldr_adrsrc", 32'(AdrSrc), 32'd1);
    check("ldr_rd_regwrite", 32'(RegWrite), 32'd0);
    step(); chk_state("ldr_memwb", S_MEMWB);
    check("ldr_wb_regwrite", 32'(RegWrite), 32'd1);
    check("ldr_resultsrc", 32'(ResultSrc), 32'd1);
    step(); chk_state("ldr_fetch", S_FETCH);

    // STR R2,[R1,#4]: MemWrite for exactly one cycle
    load(32'hE5812004);
    memw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      memw_cnt += int'(MemWrite);
    end
    check("str_memwrite_cycles", 32'(memw_cnt), 32'd1);
    chk_state("str_fetch", S_FETCH);

    // ADD PC,R0,R1
    load(32'hE080F001);
    step(); step(); chk_state("addpc_execr", S_EXECUTER);
    check("addpc_alusrcb", 32'(ALUSrcB), 32'd0);
    step(); check("addpc_pcwrite", 32'(PCWrite), 32'd1);
    check("addpc_regwrite", 32'(RegWrite), 32'd1);
    step();

    // MOVEQ R2,R3 with Z=0: condition fails
    load(32'h01A02003);
    step(); step(); check("moveq_aluctl", 32'(ALUControl), 32'd5);
    step(); check("moveq_regwrite", 32'(RegWrite), 32'd0);
    step();

    // Load non-zero flags, then reset in the middle of ADDS
    load(32'hE3520000); ALUFlags = 4'b1010;
    repeat (4) step();
    check("cmp3_flags", 32'(Flags), 32'hA);
    ALUFlags = 4'b0110;
    load(32'hE0921003);               // ADDS R1,R2,R3
    step(); step(); chk_state("adds_execr", S_EXECUTER);
    reset = 1'b0;
    step(); chk_state("midrst_state", S_FETCH);
    check("midrst_flags", 32'(Flags), 32'h0);
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    check("midrst_irwrite", 32'(IRWrite), 32'd1);
    reset = 1'b1;
    step(); chk_state("adds_redecode", S_DECODE);
    step(); step(); check("adds_flags", 32'(Flags), 32'h6);
    check("adds_regwrite", 32'(RegWrite), 32'd1);
    step(); ALUFlags = 4'b0000;

    // BL
    load(32'hEB000004);
    step();
`ifdef MC_BL_EN
    step(); chk_state("bl_brlink", S_BRLINK);
    check("bl_linkwrite", 32'(LinkWrite), 32'd1);
    check("bl_resultsrc", 32'(ResultSrc), 32'd3);
    check("bl_regwrite", 32'(RegWrite), 32'd1);
    step(); chk_state("bl_branch", S_BRANCH);
    check("bl_br_pcwrite", 32'(PCWrite), 32'd1);
`else
    step(); chk_state("bl_branch", S_BRANCH);
    check("bl_linkwrite", 32'(LinkWrite), 32'd0);
    check("bl_br_pcwrite", 32'(PCWrite), 32'd1);
`endif
    step(); chk_state("bl_fetch", S_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
